// File: rtl/cpu_pkg.sv
// Shared CPU definitions: reset PC, the canonical NOP word and the
// instruction-fetch state encoding.
package cpu_pkg;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
   localparam logic [31:0] NOP_INST_WORD    = 32'h0000_0013;  // addi x0,x0,0

   typedef enum logic [1:0] {
      REQ  = 2'd0,
      WAIT = 2'd1,
      HOLD = 2'd2
   } fetch_state_e;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory bus: valid/ready request channel and a
// never-back-pressured valid response channel.
interface fetch_unit_if;

   logic        req_valid;
   logic [31:0] req_addr;
   logic        req_ready;
   logic        resp_valid;
   logic [31:0] resp_inst;

   modport master (
      output req_valid, req_addr,
      input  req_ready, resp_valid, resp_inst
   );

   modport slave (
      input  req_valid, req_addr,
      output req_ready, resp_valid, resp_inst
   );

endinterface

// File: rtl/pc4adder.sv
// Sequential-PC adder: pc + 4, wrapping modulo 2^32.
module pc4adder (
   input  logic [31:0] pc,
   output logic [31:0] pc4
);

   assign pc4 = pc + 32'd4;

endmodule

// File: rtl/fetch_unit.sv
// IF-stage fetch unit: owns the PC, keeps at most one fetch outstanding,
// parks a returned word in a one-entry skid buffer while ID is stalled,
// and squashes in-flight fetches on an EX redirect.
// Optional build macro FETCH_ALIGN_CHECK_EN: adds if_misalign and turns a
// misaligned redirect into a presented fault marker instead of a fetch.
module fetch_unit
   import cpu_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
   parameter logic [31:0] NOP_INST = NOP_INST_WORD
) (
   input  logic         clk,
   input  logic         rst,
   fetch_unit_if.master mem,
   input  logic         redirect_valid,
   input  logic [31:0]  redirect_pc,
   input  logic         id_stall,
   output logic         if_valid,
   output logic [31:0]  if_pc,
   output logic [31:0]  if_pc4,
   output logic [31:0]  if_inst
`ifdef FETCH_ALIGN_CHECK_EN
   ,
   output logic         if_misalign
`endif
);

   fetch_state_e state_q, state_d;
   logic [31:0]  pc_q, pc_d, pc_next;
   logic [31:0]  fetch_pc_q, fetch_pc_d;
   logic [31:0]  skid_q, skid_d;
   logic         kill_q, kill_d;
   logic [31:0]  tgt_pc, slot_pc, slot_pc4;
   logic         req_fire, slot_free, load_resp, load_skid;
   logic         if_valid_d;
   logic [31:0]  if_pc_d, if_pc4_d, if_inst_d;

`ifdef FETCH_ALIGN_CHECK_EN
   logic halt_q, halt_d, misalign_d, misaligned;
   assign tgt_pc        = redirect_pc;
   assign misaligned    = redirect_valid && (redirect_pc[1:0] != 2'b00);
   assign slot_pc       = misaligned ? redirect_pc : fetch_pc_q;
   assign mem.req_valid = (state_q == REQ) && !halt_q && !rst;
`else
   assign tgt_pc        = redirect_pc & ~32'h3;
   assign slot_pc       = fetch_pc_q;
   assign mem.req_valid = (state_q == REQ) && !rst;
`endif

   assign mem.req_addr = pc_q;
   assign req_fire     = mem.req_valid && mem.req_ready;
   assign slot_free    = !if_valid || !id_stall;

   pc4adder u_next_pc  (.pc(pc_q),    .pc4(pc_next));
   pc4adder u_slot_pc4 (.pc(slot_pc), .pc4(slot_pc4));

   // Fetch FSM next state, PC update and kill/skid bookkeeping
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      fetch_pc_d = fetch_pc_q;
      skid_d     = skid_q;
      kill_d     = kill_q;
      load_resp  = 1'b0;
      load_skid  = 1'b0;
      unique case (state_q)
         REQ: begin
            if (req_fire) begin
               fetch_pc_d = pc_q;
               pc_d       = pc_next;
               kill_d     = redirect_valid;   // accepted fetch is already stale
               state_d    = WAIT;
            end
         end
         WAIT: begin
            if (mem.resp_valid) begin
               state_d = REQ;
               kill_d  = 1'b0;
               if (!kill_q && !redirect_valid) begin
                  if (slot_free) begin
                     load_resp = 1'b1;
                  end else begin
                     skid_d  = mem.resp_inst;
                     state_d = HOLD;
                  end
               end
            end else if (redirect_valid) begin
               kill_d = 1'b1;
            end
         end
         HOLD: begin
            if (redirect_valid) begin
               state_d = REQ;                 // skid word is discarded
            end else if (!id_stall) begin
               load_skid = 1'b1;
               state_d   = REQ;
            end
         end
         default: state_d = REQ;
      endcase
      if (redirect_valid) pc_d = tgt_pc;
   end

   // IF/ID output slot: hold under stall, drain to NOP, load, flush on redirect
   always_comb begin
      if_valid_d = if_valid;
      if_pc_d    = if_pc;
      if_pc4_d   = if_pc4;
      if_inst_d  = if_inst;
      if (slot_free) begin
         if_valid_d = 1'b0;
         if_inst_d  = NOP_INST;
      end
      if (load_resp) begin
         if_valid_d = 1'b1;
         if_pc_d    = fetch_pc_q;
         if_pc4_d   = slot_pc4;
         if_inst_d  = mem.resp_inst;
      end
      if (load_skid) begin
         if_valid_d = 1'b1;
         if_pc_d    = fetch_pc_q;
         if_pc4_d   = slot_pc4;
         if_inst_d  = skid_q;
      end
      if (redirect_valid) begin
         if_valid_d = 1'b0;
         if_inst_d  = NOP_INST;
      end
`ifdef FETCH_ALIGN_CHECK_EN
      misalign_d = if_misalign;
      if (slot_free || load_resp || load_skid || redirect_valid) misalign_d = 1'b0;
      if (misaligned) begin
         if_valid_d = 1'b1;
         if_pc_d    = redirect_pc;
         if_pc4_d   = slot_pc4;
         if_inst_d  = NOP_INST;
         misalign_d = 1'b1;
      end
      halt_d = halt_q;
      if (redirect_valid) halt_d = misaligned;
`endif
   end

   // Control state and presented outputs, cleared by reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= REQ;
         pc_q     <= RESET_PC;
         kill_q   <= 1'b0;
         if_valid <= 1'b0;
         if_pc    <= 32'd0;
         if_pc4   <= 32'd0;
         if_inst  <= NOP_INST;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         kill_q   <= kill_d;
         if_valid <= if_valid_d;
         if_pc    <= if_pc_d;
         if_pc4   <= if_pc4_d;
         if_inst  <= if_inst_d;
      end
   end

   // Fetch address and skid word; only meaningful while state says so
   always_ff @(posedge clk) begin
      fetch_pc_q <= fetch_pc_d;
      skid_q     <= skid_d;
   end

`ifdef FETCH_ALIGN_CHECK_EN
   // Misalignment marker and post-fault halt
   always_ff @(posedge clk) begin
      if (rst) begin
         halt_q      <= 1'b0;
         if_misalign <= 1'b0;
      end else begin
         halt_q      <= halt_d;
         if_misalign <= misalign_d;
      end
   end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios with literal expectations, then
// randomized traffic checked against a program-order stream model.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = 32'd0;
   logic        id_stall = 1'b0;
   logic        if_valid;
   logic [31:0] if_pc, if_pc4, if_inst;

   fetch_unit_if bus();

   fetch_unit dut (
      .clk            (clk),
      .rst            (rst),
      .mem            (bus),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .id_stall       (id_stall),
      .if_valid       (if_valid),
      .if_pc          (if_pc),
      .if_pc4         (if_pc4),
      .if_inst        (if_inst)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int n_consumed = 0;

   // memory model state
   logic        pend = 1'b0;
   logic [31:0] pend_addr = 32'd0;
   int          wait_cnt = 0;
   int          mem_delay = 0;
   logic        rand_mode = 1'b0;
   logic        fire_seen = 1'b0;
   logic [31:0] fire_addr = 32'd0;

   // stream model / history
   logic        started = 1'b0;
   logic        last_rst = 1'b1;
   logic [31:0] exp_pc = 32'd0;
   logic        prev_hold = 1'b0, prev_redirect = 1'b0, prev_req_wait = 1'b0;
   logic [31:0] prev_pc = 32'd0, prev_inst = 32'd0, prev_addr = 32'd0;

   function automatic logic [31:0] memw(input logic [31:0] a);
      return a ^ 32'hAAAA_0001;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // one clock: memory reacts to the request accepted at the edge
   task automatic cyc();
      @(posedge clk);
      #1;
      bus.resp_valid = 1'b0;
      bus.resp_inst  = 32'd0;
      if (rst) begin
         pend = 1'b0;
      end else begin
         if (fire_seen) begin
            pend      = 1'b1;
            pend_addr = fire_addr;
            wait_cnt  = rand_mode ? int'($urandom_range(0, 2)) : mem_delay;
         end
         if (pend) begin
            if (wait_cnt == 0) begin
               bus.resp_valid = 1'b1;
               bus.resp_inst  = memw(pend_addr);
               pend = 1'b0;
            end else begin
               wait_cnt--;
            end
         end
      end
      #1;
   endtask

   // compare process: checks outputs against the model mid-cycle
   always @(negedge clk) begin
      logic consumed;
      consumed = 1'b0;
      if (started) begin
         if (last_rst) begin
            chk("rst_if_valid", {31'd0, if_valid}, 32'd0);
            chk("rst_if_pc", if_pc, 32'd0);
            chk("rst_if_pc4", if_pc4, 32'd0);
            chk("rst_if_inst", if_inst, 32'h0000_0013);
            chk("rst_req_addr", bus.req_addr, 32'd0);
            chk("rst_req_valid", {31'd0, bus.req_valid}, {31'd0, !rst});
         end else begin
            if (if_valid) begin
               chk("pc4", if_pc4, if_pc + 32'd4);
               chk("inst_word", if_inst, memw(if_pc));
            end else begin
               chk("nop_when_idle", if_inst, 32'h0000_0013);
            end
            if (prev_hold) begin
               chk("hold_valid", {31'd0, if_valid}, 32'd1);
               chk("hold_pc", if_pc, prev_pc);
               chk("hold_inst", if_inst, prev_inst);
            end
            if (prev_redirect) chk("flush_after_redirect", {31'd0, if_valid}, 32'd0);
            if (prev_req_wait) begin
               chk("req_held_valid", {31'd0, bus.req_valid}, 32'd1);
               chk("req_held_addr", bus.req_addr, prev_addr);
            end
            if (pend || bus.resp_valid) chk("one_outstanding", {31'd0, bus.req_valid}, 32'd0);
            if (if_valid && !id_stall && !redirect_valid && !rst) begin
               chk("stream_pc", if_pc, exp_pc);
               consumed = 1'b1;
               n_consumed++;
            end
         end
      end
      if (rst)                 exp_pc = 32'd0;
      else if (redirect_valid) exp_pc = redirect_pc & ~32'h3;
      else if (consumed)       exp_pc = exp_pc + 32'd4;
      prev_hold     = if_valid && id_stall && !redirect_valid && !rst;
      prev_pc       = if_pc;
      prev_inst     = if_inst;
      prev_redirect = redirect_valid && !rst;
      prev_req_wait = bus.req_valid && !bus.req_ready && !redirect_valid && !rst;
      prev_addr     = bus.req_addr;
      fire_seen     = bus.req_valid && bus.req_ready && !rst;
      fire_addr     = bus.req_addr;
      last_rst      = rst;
   end

   initial begin
      bus.req_ready  = 1'b0;
      bus.resp_valid = 1'b0;
      bus.resp_inst  = 32'd0;
      cyc();
      started = 1'b1;
      cyc();
      // reset state, then release
      chk("d_rst_valid", {31'd0, if_valid}, 32'd0);
      chk("d_rst_inst", if_inst, 32'h0000_0013);
      chk("d_rst_req_valid", {31'd0, bus.req_valid}, 32'd0);
      rst = 1'b0;
      bus.req_ready = 1'b1;
      #1;
      chk("d_first_req_valid", {31'd0, bus.req_valid}, 32'd1);
      chk("d_first_req_addr", bus.req_addr, 32'h0);
      cyc();
      chk("d_wait_no_req", {31'd0, bus.req_valid}, 32'd0);
      cyc();
      chk("d_lat_valid", {31'd0, if_valid}, 32'd1);
      chk("d_lat_pc", if_pc, 32'h0);
      chk("d_lat_pc4", if_pc4, 32'h4);
      chk("d_lat_inst", if_inst, 32'hAAAA_0001);
      chk("d_next_addr", bus.req_addr, 32'h4);
      // stall four cycles while the next word returns
      id_stall = 1'b1;
      cyc();
      chk("d_stall_pc_a", if_pc, 32'h0);
      cyc();
      chk("d_hold_no_req", {31'd0, bus.req_valid}, 32'd0);
      chk("d_stall_pc_b", if_pc, 32'h0);
      cyc();
      chk("d_stall_inst", if_inst, 32'hAAAA_0001);
      cyc();
      chk("d_stall_pc_c", if_pc, 32'h0);
      id_stall = 1'b0;
      cyc();
      chk("d_skid_valid", {31'd0, if_valid}, 32'd1);
      chk("d_skid_pc", if_pc, 32'h4);
      chk("d_skid_inst", if_inst, 32'hAAAA_0005);
      chk("d_skid_next_addr", bus.req_addr, 32'h8);
      // redirect while waiting; response lands one cycle later
      mem_delay = 1;
      cyc();
      chk("d_w_idle", {31'd0, if_valid}, 32'd0);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h100;
      mem_delay      = 0;
      cyc();
      redirect_valid = 1'b0;
      chk("d_kill_valid_a", {31'd0, if_valid}, 32'd0);
      chk("d_kill_no_req", {31'd0, bus.req_valid}, 32'd0);
      cyc();
      chk("d_kill_valid_b", {31'd0, if_valid}, 32'd0);
      chk("d_redir_addr", bus.req_addr, 32'h100);
      chk("d_redir_req", {31'd0, bus.req_valid}, 32'd1);
      // redirect in the same cycle the request is accepted
      redirect_valid = 1'b1;
      redirect_pc    = 32'h200;
      cyc();
      redirect_valid = 1'b0;
      chk("d_kill2_valid_a", {31'd0, if_valid}, 32'd0);
      cyc();
      chk("d_kill2_valid_b", {31'd0, if_valid}, 32'd0);
      chk("d_kill2_addr", bus.req_addr, 32'h200);
      cyc();
      cyc();
      chk("d_200_valid", {31'd0, if_valid}, 32'd1);
      chk("d_200_pc", if_pc, 32'h200);
      chk("d_200_inst", if_inst, 32'hAAAA_0201);
      // wrap-around at the top of the address space
      bus.req_ready  = 1'b0;
      redirect_valid = 1'b1;
      redirect_pc    = 32'hFFFF_FFFC;
      cyc();
      redirect_valid = 1'b0;
      bus.req_ready  = 1'b1;
      chk("d_wrap_addr", bus.req_addr, 32'hFFFF_FFFC);
      chk("d_wrap_flush", {31'd0, if_valid}, 32'd0);
      cyc();
      cyc();
      chk("d_wrap_pc", if_pc, 32'hFFFF_FFFC);
      chk("d_wrap_pc4", if_pc4, 32'h0);
      chk("d_wrap_next", bus.req_addr, 32'h0);
      // reset asserted while a word sits in the skid buffer
      id_stall = 1'b1;
      cyc();
      cyc();
      chk("d_hold_req_low", {31'd0, bus.req_valid}, 32'd0);
      chk("d_hold_pc", if_pc, 32'hFFFF_FFFC);
      rst = 1'b1;
      cyc();
      chk("d_hrst_valid", {31'd0, if_valid}, 32'd0);
      chk("d_hrst_pc", if_pc, 32'd0);
      chk("d_hrst_pc4", if_pc4, 32'd0);
      chk("d_hrst_inst", if_inst, 32'h0000_0013);
      rst = 1'b0;
      id_stall = 1'b0;
      #1;
      chk("d_hrst_req", {31'd0, bus.req_valid}, 32'd1);
      chk("d_hrst_addr", bus.req_addr, 32'h0);
      // randomized traffic
      rand_mode = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         cyc();
         bus.req_ready  = ($urandom_range(0, 3) != 0);
         id_stall       = ($urandom_range(0, 3) == 0);
         redirect_valid = ($urandom_range(0, 11) == 0);
         case ($urandom_range(0, 3))
            0:       redirect_pc = $urandom;
            1:       redirect_pc = 32'hFFFF_FFF0 + $urandom_range(0, 15);
            default: redirect_pc = $urandom_range(0, 255);
         endcase
         rst = ($urandom_range(0, 299) == 0);
      end
      rst = 1'b0;
      redirect_valid = 1'b0;
      cyc();
      cyc();
      chk("liveness", {31'd0, (n_consumed > 150)}, 32'd1);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
